display_scan: RTL
=================

Name: display_scan

Overview:
Upstream driver for the hex seven-segment decoder. It latches a 16-bit value (four hex digits) plus four decimal-point flags, then time-multiplexes them onto one shared decoder.
Each scan slot outputs one nibble to the decoder, an active-low anode select, a decimal-point flag and a blank flag. Leading-zero blanking is optional. One clock domain.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot (>=1; 1 = advance every cycle); prescaler width $clog2(CLK_DIV), min 1
LZ_BLANK, 1, 1 = suppress leading zeros on digits 3..1; 0 = always show all four digits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
value  in  16  digits to show; [3:0]=digit0 (rightmost), [15:12]=digit3
dp_in  in  4  decimal-point request per digit, bit k = digit k
load  in  1  one-cycle strobe; captures value/dp_in into shadow registers
enable  in  1  1 = scanning; 0 = display dark
nibble  out  4  hex digit to decoder input
dp_out  out  1  decimal point for current slot, active-high (top level inverts into seg[7])
an  out  4  anode select, active-low, one-hot-zero; 4'b1111 = all dark
blank  out  1  1 = current slot dark; top level forces seg to 8'hff
frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (rst_n=0, async): shadow_val=0, shadow_dp=0, prescaler=0, idx=3, nibble=0, dp_out=0, an=4'b1111, blank=1, frame_done=0. All outputs registered.
- load=1 at an edge: shadow_val<=value, shadow_dp<=dp_in. Current slot outputs are not changed. New data appears from the next tick onward, so there is no mid-slot glitch.
- Prescaler, enable=1: counts 0..CLK_DIV-1. tick = (prescaler==CLK_DIV-1). On tick, prescaler goes to 0.
- On tick, idx advances 0->1->2->3->0. Outputs are loaded in the same edge for the new idx, from the shadow contents before that edge. A load coincident with a tick is therefore visible only from the following tick.
- Slot output for digit k:
  - nibble = shadow_val[4k+3:4k], dp_out = shadow_dp[k].
  - If blanked: an=4'b1111, blank=1.
  - Otherwise: an has bit k low, others high; blank=0.
- Blank rule: digit k is blanked iff LZ_BLANK=1, k>0, shadow_val nibbles k..3 are all zero, and shadow_dp bits k..3 are all zero. Digit 0 is never blanked.
- Slot timing is identical whether a digit is blanked or not. Refresh period is always 4*CLK_DIV cycles.
- frame_done: high for exactly the one cycle after the tick edge that moves idx 3->0. Low otherwise.
- enable=0 at an edge: prescaler<=0, idx<=3, an<=4'b1111, blank<=1, dp_out<=0, frame_done<=0. nibble holds its value. Shadow registers are unaffected and load still works.
- enable re-asserted: the first tick occurs CLK_DIV cycles later, lights digit 0 and pulses frame_done.
- Reset mid-scan: immediate return to reset values, including the shadow registers.

Test Plan:
(Bench uses CLK_DIV=4, LZ_BLANK=1 unless stated.)
1. Reset: assert rst_n=0 between clock edges -> outputs go to an=1111, blank=1, nibble=0, dp_out=0, frame_done=0 without waiting for an edge. Release, enable=0 -> outputs stay dark.
2. load 16'h1234, dp_in=0, enable=1:
   - 4 cycles later an=1110, nibble=4, frame_done=1 for one cycle.
   - Then every 4 cycles: an=1101/3, an=1011/2, an=0111/1, wrapping back to 1110/4.
   - frame_done pulses every 16 cycles.
3. Leading-zero blanking:
   - load 16'h0045 -> digit3/digit2 slots show an=1111, blank=1; digit1 shows nibble=4, digit0 shows nibble=5.
   - load 16'h0000 -> only digit0 is lit, nibble=0.
   - load 16'h0005, dp_in=4'b0100 -> digit2 is lit, nibble=0, dp_out=1; digit3 is blank.
   - Repeat with LZ_BLANK=0 -> all four digits are lit.
4. Load mid-slot: value 16'h1234, load 16'hABCD while digit1 is lit -> digit1 keeps nibble=3 until the tick; digit2 then shows B, digit3 shows A.
   - Also pulse load on the same cycle as a tick -> that slot shows the old nibble; the next slot shows new data.
5. Enable drop mid-scan: enable=0 while digit2 is lit -> next edge an=1111, blank=1.
   - Re-enable -> digit0 is lit exactly CLK_DIV cycles later and frame_done pulses.
   - The shadow still holds the last loaded value.
6. CLK_DIV=1: idx advances every cycle, frame_done pulses every 4th cycle, and no slot is skipped or repeated.

Source files
------------

// File: rtl/display_scan.sv
// rtl/display_scan.sv - four-digit hex scan driver for a shared seven-segment decoder
module display_scan #(
  parameter int CLK_DIV  = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  nibble,
  output logic        dp_out,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic [PW-1:0] prescaler;
  logic [1:0]    idx;

  logic          tick;
  logic [1:0]    next_idx;
  logic [3:0]    next_nibble;
  logic          next_dp;
  logic          upper_zero;
  logic          next_blank;

  // Slot contents for the digit that the next tick will select, taken from the current shadow
  always_comb begin
    tick        = (prescaler == PS_MAX);
    next_idx    = idx + 2'd1;
    next_nibble = shadow_val[{next_idx, 2'b00} +: 4];
    next_dp     = shadow_dp[next_idx];
    upper_zero  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(next_idx)) begin
        if (shadow_val[4*j +: 4] != 4'd0 || shadow_dp[j]) begin
          upper_zero = 1'b0;
        end
      end
    end
    next_blank = (LZ_BLANK != 0) && (next_idx != 2'd0) && upper_zero;
  end

  // Shadow capture, prescaler, slot index and registered slot outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      prescaler  <= '0;
      idx        <= 2'd3;
      nibble     <= '0;
      dp_out     <= 1'b0;
      an         <= 4'b1111;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (!enable) begin
        prescaler  <= '0;
        idx        <= 2'd3;
        an         <= 4'b1111;
        blank      <= 1'b1;
        dp_out     <= 1'b0;
        frame_done <= 1'b0;
      end else if (tick) begin
        prescaler  <= '0;
        idx        <= next_idx;
        nibble     <= next_nibble;
        dp_out     <= next_dp;
        blank      <= next_blank;
        an         <= next_blank ? 4'b1111 : ~(4'b0001 << next_idx);
        frame_done <= (next_idx == 2'd0);
      end else begin
        prescaler  <= prescaler + 1'b1;
        frame_done <= 1'b0;
      end
    end
  end

endmodule
